// File: rtl/double_pulse_pkg.sv
// Shared definitions for the two-phase write-strobe receiver: FSM encoding,
// error-flag bit positions and default widths.
package double_pulse_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StArmed = 1'b1
    } dp_state_e;

    localparam int unsigned ERR_OVERLAP = 0;
    localparam int unsigned ERR_ORPHAN  = 1;
    localparam int unsigned ERR_MISSING = 2;
    localparam int unsigned NUM_ERR     = 3;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned ERR_CNT_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; a clear in the same
// cycle as an increment leaves the counter at 1.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != {W{1'b1}})) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/double_pulse_rx.sv
// Two-phase write-strobe receiver: master capture on phase 1, slave commit on
// phase 2, sticky protocol-error flags. Optional macro DOUBLE_PULSE_RX_ERR_CNT_EN adds err_cnt_o.
module double_pulse_rx
    import double_pulse_pkg::*;
#(
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        CNT_W    = DEF_CNT_W,
    parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ph1_i,
    input  logic              ph2_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  xfer_cnt_o,
`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
    output logic              err_overlap_o,
    output logic              err_orphan_o,
    output logic              err_missing_o,
    output logic              err_o
);

    dp_state_e           state_q, state_d;
    logic [DATA_W-1:0]   master_q, master_d;
    logic [DATA_W-1:0]   slave_q, slave_d;
    logic                valid_q, valid_d;
    logic [NUM_ERR-1:0]  err_q, err_d, err_ev;
    logic                xfer_inc;

    always_comb begin
        state_d  = state_q;
        master_d = master_q;
        slave_d  = slave_q;
        valid_d  = 1'b0;
        err_ev   = '0;
        xfer_inc = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ph1_i && !ph2_i) begin
                    master_d = data_i;
                    state_d  = StArmed;
                end else if (ph1_i && ph2_i) begin
                    err_ev[ERR_OVERLAP] = 1'b1;
                end else if (ph2_i) begin
                    err_ev[ERR_ORPHAN] = 1'b1;
                end
            end
            StArmed: begin
                if (!ph1_i && ph2_i) begin
                    slave_d  = master_q;
                    valid_d  = 1'b1;
                    xfer_inc = 1'b1;
                    state_d  = StIdle;
                end else if (ph1_i && ph2_i) begin
                    // Master contents are abandoned; they never reach the slave.
                    err_ev[ERR_OVERLAP] = 1'b1;
                    state_d             = StIdle;
                end else if (ph1_i) begin
                    err_ev[ERR_MISSING] = 1'b1;
                    master_d            = data_i;
                end else begin
                    err_ev[ERR_MISSING] = 1'b1;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_d = (clear_i ? '0 : err_q) | err_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            master_q <= RST_DATA;
            slave_q  <= RST_DATA;
            valid_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            slave_q  <= slave_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_i),
        .inc   (xfer_inc),
        .q     (xfer_cnt_o)
    );

`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_i),
        .inc   (|err_ev),
        .q     (err_cnt_o)
    );
`endif

    assign data_o        = slave_q;
    assign valid_o       = valid_q;
    assign busy_o        = (state_q == StArmed);
    assign err_overlap_o = err_q[ERR_OVERLAP];
    assign err_orphan_o  = err_q[ERR_ORPHAN];
    assign err_missing_o = err_q[ERR_MISSING];
    assign err_o         = |err_q;

endmodule

// File: tb/tb_double_pulse_rx.sv
// Directed bench for double_pulse_rx: a default-width instance and a CNT_W=2
// instance share stimulus; expected values are hand-computed.
module tb_double_pulse_rx;

    logic       clk = 1'b0;
    logic       reset, ph1, ph2, clr;
    logic [7:0] din;

    logic [7:0]  data_o, data2_o;
    logic        valid_o, busy_o, valid2_o, busy2_o;
    logic [15:0] cnt_o;
    logic [1:0]  cnt2_o;
    logic        ovl_o, orp_o, mis_o, err_o;
    logic        ovl2_o, orp2_o, mis2_o, err2_o;
`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
    logic [7:0]  ecnt_o, ecnt2_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    double_pulse_rx #(.DATA_W(8), .CNT_W(16), .RST_DATA(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .ph1_i         (ph1),
        .ph2_i         (ph2),
        .data_i        (din),
        .clear_i       (clr),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .xfer_cnt_o    (cnt_o),
`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
        .err_cnt_o     (ecnt_o),
`endif
        .err_overlap_o (ovl_o),
        .err_orphan_o  (orp_o),
        .err_missing_o (mis_o),
        .err_o         (err_o)
    );

    double_pulse_rx #(.DATA_W(8), .CNT_W(2), .RST_DATA(8'h00)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .ph1_i         (ph1),
        .ph2_i         (ph2),
        .data_i        (din),
        .clear_i       (clr),
        .data_o        (data2_o),
        .valid_o       (valid2_o),
        .busy_o        (busy2_o),
        .xfer_cnt_o    (cnt2_o),
`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
        .err_cnt_o     (ecnt2_o),
`endif
        .err_overlap_o (ovl2_o),
        .err_orphan_o  (orp2_o),
        .err_missing_o (mis2_o),
        .err_o         (err2_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p1, input logic p2, input logic [7:0] d, input logic c);
        ph1 = p1;
        ph2 = p2;
        din = d;
        clr = c;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_err", {ovl_o, orp_o, mis_o, err_o}, 0);

        // Single transfer
        drive(1'b1, 1'b0, 8'hA5, 1'b0); tick();
        check("single_busy", busy_o, 1);
        check("single_valid_early", valid_o, 0);
        drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
        check("single_data", data_o, 8'hA5);
        check("single_valid", valid_o, 1);
        check("single_busy_done", busy_o, 0);
        check("single_cnt", cnt_o, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
        check("single_valid_pulse", valid_o, 0);
        check("single_err", err_o, 0);

        // Back-to-back transfers
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0); tick();
            check("b2b_busy", busy_o, 1);
            check("b2b_valid_lo", valid_o, 0);
            drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
            check("b2b_valid_hi", valid_o, 1);
            check("b2b_data", data_o, 32'(i));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
        check("b2b_cnt", cnt_o, 4);
        check("b2b_err", err_o, 0);

        // Orphan ph2
        do_reset();
        drive(1'b0, 1'b1, 8'h5A, 1'b0); tick();
        check("orphan_flag", orp_o, 1);
        check("orphan_err", err_o, 1);
        check("orphan_data", data_o, 8'h00);
        check("orphan_valid", valid_o, 0);

        // Overlap in IDLE, then in ARMED
        do_reset();
        drive(1'b1, 1'b1, 8'h66, 1'b0); tick();
        check("ovl_idle_flag", ovl_o, 1);
        check("ovl_idle_busy", busy_o, 0);
        check("ovl_idle_valid", valid_o, 0);
        do_reset();
        drive(1'b1, 1'b0, 8'h77, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h00, 1'b0); tick();
        check("ovl_armed_flag", ovl_o, 1);
        check("ovl_armed_busy", busy_o, 0);
        check("ovl_armed_valid", valid_o, 0);
        check("ovl_armed_data", data_o, 8'h00);
        check("ovl_armed_cnt", cnt_o, 0);

        // Missing ph2
        do_reset();
        drive(1'b1, 1'b0, 8'h44, 1'b0); tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
        check("miss_flag", mis_o, 1);
        check("miss_busy", busy_o, 0);
        check("miss_valid", valid_o, 0);
        tick();
        check("miss_valid_after", valid_o, 0);
        check("miss_other_flags", {ovl_o, orp_o}, 0);

        // Recapture
        do_reset();
        drive(1'b1, 1'b0, 8'h11, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h22, 1'b0); tick();
        check("recap_missing", mis_o, 1);
        check("recap_busy", busy_o, 1);
        drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
        check("recap_data", data_o, 8'h22);
        check("recap_valid", valid_o, 1);
        check("recap_cnt", cnt_o, 1);

        // Reset while ARMED
        do_reset();
        drive(1'b1, 1'b0, 8'h33, 1'b0); tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstarm_busy", busy_o, 0);
        check("rstarm_data", data_o, 8'h00);
        drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
        check("rstarm_valid", valid_o, 0);
        check("rstarm_orphan", orp_o, 1);
        check("rstarm_data2", data_o, 8'h00);

        // clear_i with concurrent events
        do_reset();
        drive(1'b1, 1'b0, 8'h9C, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h00, 1'b0); tick();
        check("clr_pre_cnt", cnt_o, 1);
        check("clr_pre_ovl", ovl_o, 1);
        drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
        check("clr_orphan_flag", orp_o, 1);
        check("clr_orphan_ovl", ovl_o, 0);
        check("clr_orphan_cnt", cnt_o, 0);
        check("clr_keeps_data", data_o, 8'h9C);
        drive(1'b1, 1'b0, 8'hC3, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
        check("clr_cnt_before", cnt_o, 1);
        drive(1'b1, 1'b0, 8'hD4, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
        check("clr_xfer_cnt", cnt_o, 1);
        check("clr_xfer_err", err_o, 0);
        check("clr_xfer_valid", valid_o, 1);
        check("clr_xfer_data", data_o, 8'hD4);
        drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
        check("clr_keeps_data2", data_o, 8'hD4);

        // Saturation with CNT_W = 2
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 8'(i + 8'h40), 1'b0); tick();
            drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
            check("sat_cnt2", cnt2_o, (i > 3) ? 3 : i);
            check("sat_cnt16", cnt_o, i);
        end
        check("sat_err", err2_o, 0);

`ifdef DOUBLE_PULSE_RX_ERR_CNT_EN
        do_reset();
        check("ecnt_rst", ecnt_o, 0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        check("ecnt_sat", ecnt_o, 255);
        drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
        check("ecnt_clr", ecnt_o, 0);
        drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
        check("ecnt_clr_ev", ecnt_o, 1);
`endif

        drive(1'b0, 1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/double_pulse_rx.md
Name: double_pulse_rx

Overview:
- Receiving end of the two-phase write-strobe protocol used by the CBA pixel-array components.
- The transmitter issues a phase-1 qualifier, then a phase-2 qualifier one cycle later.
- This block samples the registered phase qualifiers and the write data on clk:
  - captures data into a master stage on phase 1;
  - commits it to a slave stage on phase 2.
- It flags protocol violations and counts completed transfers.
- It sits at the array-periphery end of a configuration/latch write path, and serves as a synchronous checker in the Rd53a testbench.

Parameters:
- DATA_W, 8, width of data_i/data_o.
- CNT_W, 16, width of xfer_cnt_o (saturating).
- RST_DATA, 0, value loaded into master and slave stages on reset.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- ph1_i  in  1  phase-1 qualifier (registered, one cycle per strobe).
- ph2_i  in  1  phase-2 qualifier (registered, one cycle per strobe).
- data_i  in  DATA_W  write data; sampled only when ph1_i is accepted.
- clear_i  in  1  synchronous clear of sticky errors and xfer_cnt_o.
- data_o  out  DATA_W  slave-stage contents.
- valid_o  out  1  one-cycle pulse when data_o updates.
- busy_o  out  1  high while in ARMED (phase 1 seen, awaiting phase 2).
- xfer_cnt_o  out  CNT_W  completed-transfer count.
- err_overlap_o  out  1  sticky; ph1_i and ph2_i high in the same cycle.
- err_orphan_o  out  1  sticky; ph2_i seen in IDLE.
- err_missing_o  out  1  sticky; ARMED cycle without ph2_i.
- err_o  out  1  OR of the three sticky flags.

Behaviour:
- Reset values:
  - state IDLE;
  - master and slave stages = RST_DATA, so data_o = RST_DATA;
  - valid_o = 0, busy_o = 0, xfer_cnt_o = 0;
  - all error flags = 0.
- Reset mid-transfer (in ARMED) discards the master stage and returns to IDLE.
- All outputs are registered, except err_o, which is combinational from the registered flags.
- FSM with two states, IDLE and ARMED. Transitions are evaluated each posedge:
  - IDLE, ph1 & !ph2: master <= data_i; go to ARMED.
  - IDLE, ph1 & ph2: set overlap; no capture; stay IDLE.
  - IDLE, !ph1 & ph2: set orphan; stay IDLE.
  - ARMED, !ph1 & ph2: slave <= master; valid_o = 1 next cycle; xfer_cnt +1; go to IDLE.
  - ARMED, ph1 & ph2: set overlap; discard master; go to IDLE; no valid.
  - ARMED, ph1 & !ph2: set missing; master <= data_i (recapture); stay ARMED.
  - ARMED, !ph1 & !ph2: set missing; go to IDLE.
- Latency: ph2_i accepted at edge n gives data_o/valid_o updated at edge n+1.
- Back-to-back transfers: the pattern ph1, ph2, ph1, ph2 on consecutive cycles is legal. It yields a valid_o pulse every 2 cycles with no errors.
- busy_o is high for exactly one cycle per legal transfer.
- xfer_cnt_o saturates at 2^CNT_W-1 and does not wrap.
- clear_i:
  - clears the sticky flags and xfer_cnt_o;
  - does not affect state, master, slave or valid_o.
- clear_i coinciding with an event: clear is applied first, then the event's set/increment. The new error flag is 1; the counter becomes 1 if a transfer completes that cycle.
- reset has priority over clear_i and all events.

Optional Feature:
- Macro: DOUBLE_PULSE_RX_ERR_CNT_EN.
- When defined:
  - adds port err_cnt_o, out, 8 bits, a saturating count of every error event (each of the three conditions per cycle counts once);
  - err_cnt_o is cleared by reset and clear_i, following the same same-cycle rule as xfer_cnt_o.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package double_pulse_pkg holds:
  - the FSM state encoding (IDLE = 1'b0, ARMED = 1'b1);
  - error-index constants (ERR_OVERLAP = 0, ERR_ORPHAN = 1, ERR_MISSING = 2);
  - the default widths.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q) is instantiated for xfer_cnt_o and for err_cnt_o when the optional feature is enabled.

Test Plan:
- Single transfer: data_i = 8'hA5 with ph1 at cycle 2, ph2 at cycle 3 -> data_o = A5 and valid_o = 1 at cycle 4 only; busy_o high at cycle 3 only; xfer_cnt_o = 1; err_o = 0.
- Back-to-back: 4 ph1/ph2 pairs with data 01, 02, 03, 04 on consecutive cycles -> 4 valid_o pulses, 2 cycles apart; data_o ends at 04; xfer_cnt_o = 4; no errors.
- Violations (reset between each):
  - ph2 alone -> err_orphan_o = 1, data_o unchanged;
  - ph1 & ph2 together -> err_overlap_o = 1, no valid_o;
  - ph1 then idle -> err_missing_o = 1, state returns to IDLE, no valid_o.
- Recapture: ph1 with data 11, then ph1 with data 22, then ph2 -> err_missing_o = 1; data_o = 22; xfer_cnt_o = 1.
- Reset/clear:
  - reset asserted in ARMED -> no valid_o; data_o = RST_DATA;
  - clear_i in the same cycle as an orphan ph2 -> err_orphan_o = 1, xfer_cnt_o = 0;
  - with CNT_W = 2, 5 transfers -> xfer_cnt_o saturates at 3.
- With DOUBLE_PULSE_RX_ERR_CNT_EN defined: 300 orphan strobes -> err_cnt_o = 255 (saturated); clear_i -> err_cnt_o = 0.
